// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: exception-code
// defaults, payload field widths and a helper that sizes the packed
// payload bundle {pc, alu, wdata, rd, exc, bd}.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int EXC_W_DEF  = 5;
    localparam int RD_W       = 5;
    localparam int BD_W       = 1;

    // Exception code meaning "no exception".
    localparam logic [EXC_W_DEF-1:0] EXC_NONE = '0;

    // Total width of one packed EM payload bundle.
    function automatic int em_payload_w(input int data_w, input int exc_w);
        return 3 * data_w + RD_W + exc_w + BD_W;
    endfunction

endpackage

// File: rtl/em_skid_slot.sv
// One storage slot of the EM stage: a payload register plus valid bit.
// Clear drops only the valid bit; the payload keeps its last value so the
// outputs stay quiet while the slot is empty. Clear wins over load.
module em_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    logic [W-1:0] data_reg;
    logic         valid_reg;

    // Payload and valid bit update; reset zeroes both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= d;
            valid_reg <= 1'b1;
        end
    end

    assign q     = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/pipe_stage_em.sv
// EX->MEM pipeline register with valid/ready handshake, flush and an
// exception fence (no new entries while an excepting entry is held).
// Build option PIPE_EM_SKID_EN: when defined, a two-entry head+skid buffer
// with a registered in_ready; otherwise a single entry with combinational
// in_ready. Both modes are cycle-identical while out_ready stays high.
module pipe_stage_em import pipe_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXC_W  = EXC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [RD_W-1:0]   out_rd,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic              exc_pending
);

    localparam int PW = em_payload_w(DATA_W, EXC_W);
`ifdef PIPE_EM_SKID_EN
    localparam int NUM_SLOTS = 2;
`else
    localparam int NUM_SLOTS = 1;
`endif

    logic [PW-1:0]        in_payload;
    logic [PW-1:0]        slot_d [NUM_SLOTS];
    logic [PW-1:0]        slot_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_load;
    logic [NUM_SLOTS-1:0] slot_clear;
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [NUM_SLOTS-1:0] slot_exc;

    logic head_valid;
    logic fence;
    logic accept;
    logic release_head;

    assign in_payload = {in_pc, in_alu, in_wdata, in_rd, in_exc, in_bd};

    // Slot 0 is the head (drives out_*); slot 1, when present, is the skid.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            em_skid_slot #(.W(PW)) u_slot (
                .clk   (clk),
                .reset (reset),
                .load  (slot_load[gi]),
                .clear (slot_clear[gi]),
                .d     (slot_d[gi]),
                .q     (slot_q[gi]),
                .valid (slot_valid[gi])
            );
            assign slot_exc[gi] = slot_valid[gi] &&
                                  (slot_q[gi][EXC_W:1] != EXC_W'(EXC_NONE));
        end
    endgenerate

    assign head_valid   = slot_valid[0];
    assign fence        = |slot_exc;
    assign accept       = in_valid && in_ready && !flush;
    assign release_head = head_valid && out_ready && !flush;

`ifdef PIPE_EM_SKID_EN
    logic skid_valid;
    logic in_ready_reg;
    logic in_ready_next;
    logic head_exc_next;
    logic skid_exc_next;
    logic skid_valid_next;

    assign skid_valid = slot_valid[1];

    // Head refills from the skid first; the skid only catches an accept
    // that arrives while the head is stalled.
    always_comb begin
        slot_d[0]     = skid_valid ? slot_q[1] : in_payload;
        slot_d[1]     = in_payload;
        slot_load[0]  = (release_head && skid_valid) ||
                        (accept && (!head_valid || release_head));
        slot_clear[0] = flush || (release_head && !skid_valid && !accept);
        slot_load[1]  = accept && head_valid && !release_head;
        slot_clear[1] = flush || (release_head && skid_valid);
    end

    // Look-ahead of the slot state so in_ready can be a plain register.
    always_comb begin
        head_exc_next   = slot_exc[0];
        skid_exc_next   = slot_exc[1];
        skid_valid_next = skid_valid;
        if (slot_clear[0]) begin
            head_exc_next = 1'b0;
        end else if (slot_load[0]) begin
            head_exc_next = (slot_d[0][EXC_W:1] != EXC_W'(EXC_NONE));
        end
        if (slot_clear[1]) begin
            skid_exc_next   = 1'b0;
            skid_valid_next = 1'b0;
        end else if (slot_load[1]) begin
            skid_exc_next   = (in_exc != EXC_W'(EXC_NONE));
            skid_valid_next = 1'b1;
        end
        in_ready_next = !skid_valid_next && !head_exc_next && !skid_exc_next;
    end

    // Registered ready: skid free and nothing fenced.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_reg <= 1'b1;
        end else begin
            in_ready_reg <= in_ready_next;
        end
    end

    assign in_ready = in_ready_reg;
`else
    // Single entry: load on accept, drop on a release with nothing behind it.
    always_comb begin
        slot_d[0]     = in_payload;
        slot_load[0]  = accept;
        slot_clear[0] = flush || (release_head && !accept);
    end

    assign in_ready = (!head_valid || out_ready) && !fence;
`endif

    assign out_valid   = head_valid;
    assign exc_pending = slot_exc[0];
    assign {out_pc, out_alu, out_wdata, out_rd, out_exc, out_bd} = slot_q[0];

endmodule
